// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: two-digit BCD to 7-bit binary via seven reverse double-dabble iterations.
// Define BCD2BIN_RANGE_CHECK_EN to add the err port and short-circuit invalid digits.
module bcd2bin_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] bin,
  output logic       busy,
  output logic       done
`ifdef BCD2BIN_RANGE_CHECK_EN
  ,
  output logic       err
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state, state_nx;
  logic [7:0]  bcd, bcd_nx;
  logic [6:0]  sh, sh_nx, bin_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [14:0] shr;
  logic [3:0]  hi, lo;
  logic        cap, bad;
  assign shr  = {1'b0, bcd, sh[6:1]};
  assign hi   = shr[14:11] >= 4'd8 ? shr[14:11] - 4'd3 : shr[14:11];
  assign lo   = shr[10:7]  >= 4'd8 ? shr[10:7]  - 4'd3 : shr[10:7];
  assign cap  = state != SHIFT && start;
  assign busy = state == SHIFT;
  assign done = state == DONE;
`ifdef BCD2BIN_RANGE_CHECK_EN
  assign bad = tens > 4'd9 || ones > 4'd9;
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    bcd_nx   = bcd;
    sh_nx    = sh;
    cnt_nx   = cnt;
    bin_nx   = bin;
    if (cap) begin
      bcd_nx   = {tens, ones};
      sh_nx    = '0;
      cnt_nx   = '0;
      state_nx = bad ? DONE : SHIFT;
      bin_nx   = bad ? 7'd0 : bin;
    end else if (state == SHIFT) begin
      bcd_nx   = {hi, lo};
      sh_nx    = shr[6:0];
      cnt_nx   = cnt + 3'd1;
      state_nx = cnt == 3'd6 ? DONE : SHIFT;
      bin_nx   = cnt == 3'd6 ? shr[6:0] : bin;
    end else if (state == DONE) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bcd   <= '0;
      sh    <= '0;
      cnt   <= '0;
      bin   <= '0;
    end else begin
      state <= state_nx;
      bcd   <= bcd_nx;
      sh    <= sh_nx;
      cnt   <= cnt_nx;
      bin   <= bin_nx;
    end
  end
`ifdef BCD2BIN_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    err <= 1'b0;
    else if (cap) err <= bad;
  end
`endif
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed table and corner-case sequences for bcd2bin_seq.
module tb_bcd2bin_seq;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] tens = '0, ones = '0;
  logic [6:0] bin;
  logic       busy, done;
`ifdef BCD2BIN_RANGE_CHECK_EN
  logic       err;
`endif
  int total = 0, bad = 0;
  typedef struct {logic [3:0] t; logic [3:0] o; int exp;} vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  bcd2bin_seq dut (
    .clk(clk), .reset(reset), .start(start), .tens(tens), .ones(ones),
    .bin(bin), .busy(busy), .done(done)
`ifdef BCD2BIN_RANGE_CHECK_EN
    , .err(err)
`endif
  );
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic convert(input logic [3:0] t, input logic [3:0] o, input int exp, input string nm);
    int steps, bsy, chg;
    logic [6:0] prev;
    steps = 0; bsy = 0; chg = 0; prev = bin;
    tens = t; ones = o; start = 1'b1;
    step();
    start = 1'b0; tens = ~t; ones = ~o;
    while (!done && steps < 20) begin
      if (busy) bsy++;
      if (bin != prev) chg++;
      step();
      steps++;
    end
    check({nm, " latency"}, steps, 7);
    check({nm, " busy cycles"}, bsy, 7);
    check({nm, " bin hold"}, chg, 0);
    check({nm, " bin"}, int'(bin), exp);
    check({nm, " busy at done"}, int'(busy), 0);
    step();
    check({nm, " done width"}, int'(done), 0);
  endtask
  initial begin
    int dcnt;
    vecs[0] = '{4'd4, 4'd2, 42};
    vecs[1] = '{4'd0, 4'd0, 0};
    vecs[2] = '{4'd9, 4'd9, 99};
    vecs[3] = '{4'd1, 4'd5, 15};
    vecs[4] = '{4'd5, 4'd0, 50};
    vecs[5] = '{4'd0, 4'd9, 9};
    vecs[6] = '{4'd7, 4'd3, 73};
    vecs[7] = '{4'd8, 4'd8, 88};
    step();
    check("reset bin", int'(bin), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
`ifdef BCD2BIN_RANGE_CHECK_EN
    check("reset err", int'(err), 0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 8; i++) convert(vecs[i].t, vecs[i].o, vecs[i].exp, $sformatf("vec%0d", i));
    for (int t = 0; t < 10; t++)
      for (int o = 0; o < 10; o++) convert(4'(t), 4'(o), 10 * t + o, $sformatf("sweep %0d%0d", t, o));
    tens = 4'd9; ones = 4'd9; start = 1'b1;
    step();
    tens = 4'd0; ones = 4'd7;
    repeat (6) step();
    check("b2b busy before done", int'(busy), 1);
    step();
    check("b2b done1", int'(done), 1);
    check("b2b bin1", int'(bin), 99);
    step();
    check("b2b recapture busy", int'(busy), 1);
    check("b2b done width", int'(done), 0);
    start = 1'b0;
    repeat (7) step();
    check("b2b done2", int'(done), 1);
    check("b2b bin2", int'(bin), 7);
    step();
    check("b2b idle", int'(busy), 0);
    tens = 4'd3; ones = 4'd6; start = 1'b1;
    step();
    start = 1'b0; tens = 4'd0; ones = 4'd0;
    repeat (2) step();
    tens = 4'd8; ones = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("ignore busy", int'(busy), 1);
    check("ignore no early done", int'(done), 0);
    step();
    check("ignore done", int'(done), 1);
    check("ignore bin", int'(bin), 36);
    step();
    check("ignore no restart", int'(busy), 0);
    tens = 4'd6; ones = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    check("async rst bin", int'(bin), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst done", int'(done), 0);
    start = 1'b1;
    repeat (2) step();
    check("start under reset", int'(busy), 0);
    start = 1'b0; reset = 1'b0;
    dcnt = 0;
    repeat (10) begin
      step();
      if (done) dcnt++;
    end
    check("aborted no done", dcnt, 0);
    convert(4'd1, 4'd5, 15, "post reset");
`ifdef BCD2BIN_RANGE_CHECK_EN
    tens = 4'hA; ones = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("range done", int'(done), 1);
    check("range bin", int'(bin), 0);
    check("range err", int'(err), 1);
    check("range busy", int'(busy), 0);
    step();
    check("range done width", int'(done), 0);
    convert(4'd2, 4'd0, 20, "after range");
    check("range err clear", int'(err), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001: The block SHALL have a single clock and an asynchronous, active-high reset, with ports as follows: clk, input, 1, rising-edge clock.
REQ-002: reset, input, 1, asynchronous active-high reset.
REQ-003: start, input, 1, conversion request; sampled on rising clk.
REQ-004: tens, input, 4, BCD tens digit.
REQ-005: ones, input, 4, BCD ones digit.
REQ-006: bin, output, 7, registered binary result (0..99).
REQ-007: busy, output, 1, high while a conversion is in progress.
REQ-008: done, output, 1, single-cycle result-valid pulse.
REQ-009: err, output, 1, invalid-digit flag; exists only when BCD2BIN_RANGE_CHECK_EN is defined.
REQ-010: The block SHALL have no parameters; widths are fixed as listed.

Function
REQ-011: The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-012: In IDLE or DONE, start=1 at a clk edge SHALL capture {tens,ones} into an 8-bit BCD shift register, clear the 7-bit binary shift register and the 3-bit iteration count, and enter SHIFT.
REQ-013: start SHALL be ignored while in SHIFT; the inputs need only be stable on the capturing edge.
REQ-014: Each SHIFT edge SHALL perform one iteration: shift right by 1 the 15-bit concatenation {bcd, binreg}, then subtract 3 from each BCD nibble that is >= 8, all within the same cycle.
REQ-015: After the 7th iteration the FSM SHALL enter DONE, load bin from the binary shift register, and assert done.
REQ-016: Latency SHALL be exactly 7 cycles: done is high in the 7th cycle after the capturing edge.
REQ-017: done SHALL be high for exactly one cycle; DONE SHALL return to IDLE on the next edge unless start=1, in which case a new conversion begins (back-to-back operation).
REQ-018: busy SHALL be 1 exactly while in SHIFT.
REQ-019: bin SHALL hold its last result until the next DONE and SHALL not change while in SHIFT.
REQ-020: For valid digits, the result SHALL satisfy bin = 10*tens + ones; inputs 0x00 and 0x99 SHALL yield 0 and 99.

Reset
REQ-021: Asserting reset SHALL force IDLE immediately, regardless of clk.
REQ-022: Reset SHALL clear bin, busy, done, err, the iteration count and both shift registers to 0.
REQ-023: Reset asserted mid-conversion SHALL abort it with no done pulse; start SHALL be ignored while reset is high.
REQ-024: The first conversion SHALL be accepted on the first clk edge after reset deasserts with start=1.

Configuration
REQ-025: The macro BCD2BIN_RANGE_CHECK_EN SHALL control range checking.
REQ-026: With the macro defined, if tens>9 or ones>9 at capture, the FSM SHALL go directly to DONE on the next edge, setting bin=0 and err=1 with a single done pulse; err SHALL clear on the next valid capture or on reset.
REQ-027: With the macro undefined, the err port SHALL be absent, invalid digits SHALL run the normal 7-iteration conversion, and the result is unspecified.

Verification
REQ-028: The bench SHALL cover each of the following directed scenarios.
REQ-029: Reset, then tens=4, ones=2, start pulse -> busy for 7 cycles, done pulses in cycle 7, bin=42.
REQ-030: Sweep all 100 valid digit pairs, one per conversion -> bin = 10*tens+ones every time, done one cycle wide each time.
REQ-031: start held high continuously with 9/9 then 0/7 -> bin=99 then bin=7, with a new capture on each DONE edge and no idle gap.
REQ-032: start pulsed again in SHIFT cycle 3 with different digits -> ignored; the original result is delivered at cycle 7.
REQ-033: reset asserted asynchronously in SHIFT cycle 4 -> outputs 0 immediately, no done pulse; a subsequent 1/5 conversion yields 15.
REQ-034: With BCD2BIN_RANGE_CHECK_EN defined, tens=0xA, ones=3 -> done one cycle after capture, bin=0, err=1; then 2/0 -> err=0, bin=20.
